// File: rtl/clock_adjust_ctrl.sv
// Wall-clock UI controller: button sync/debounce, run/adjust FSM,
// counter strobes, display select and digit blink.
module clock_adjust_ctrl #(
  parameter int DEBOUNCE_MS     = 20,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_MS       = 200,
  parameter int BLINK_MS        = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1ms,
  input  logic       btn_mode,
  input  logic       btn_sel,
  input  logic       btn_inc,
  output logic [1:0] disp_mode,
  output logic       adjust,
  output logic       sec_hold,
  output logic       sec_clr,
  output logic       inc_min,
  output logic       inc_hour,
  output logic [3:0] t_blink
);

  localparam int DBW = $clog2(DEBOUNCE_MS + 1);
  localparam int HW  = $clog2(REPEAT_DELAY_MS + REPEAT_MS + 1);
  localparam int BW  = $clog2(BLINK_MS + 1);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] ADJ_MIN  = 2'd1;
  localparam logic [1:0] ADJ_HOUR = 2'd2;
  localparam logic [1:0] ADJ_SEC  = 2'd3;

  // bit 0 mode, bit 1 sel, bit 2 inc
  logic [2:0]     btn_raw;
  logic [2:0]     sync1_q, sync2_q;
  logic [2:0]     stable_q, stable_d;
  logic [2:0]     prev_q;
  logic [2:0]     armed_q, armed_d;
  logic [DBW-1:0] db_q [3];
  logic [DBW-1:0] db_d [3];
  logic [2:0]     press;
  logic           p_mode, p_sel, p_inc;

  logic [1:0]     state_q, state_d;
  logic [1:0]     run_q, run_d;
  logic           st_chg;

  logic           rep_en, rep_fire;
  logic [HW-1:0]  hold_q, hold_d;

  logic [BW-1:0]  blk_q, blk_d;
  logic           phase_q, phase_d;

  logic           sec_hold_q;
  logic           inc_min_q, inc_hour_q, sec_clr_q;
  logic           inc_ev;
  logic [3:0]     mask;

  assign btn_raw = {btn_inc, btn_sel, btn_mode};

  // A button held through reset must be seen released before it can press
  assign armed_d = armed_q | ~sync2_q;
  assign press   = stable_q & ~prev_q & armed_q;
  assign p_mode  = press[0];
  assign p_sel   = press[1] & ~press[0];
  assign p_inc   = press[2] & ~press[0] & ~press[1];

  // Per-button debounce counters advance only on 1 ms ticks
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < 3; i++) begin
      db_d[i] = db_q[i];
      if (tick_1ms) begin
        if (sync2_q[i] != stable_q[i]) begin
          if (db_q[i] == DBW'(DEBOUNCE_MS - 1)) begin
            stable_d[i] = ~stable_q[i];
            db_d[i]     = '0;
          end else begin
            db_d[i] = db_q[i] + DBW'(1);
          end
        end else begin
          db_d[i] = '0;
        end
      end
    end
  end

  // Run/adjust state and run-mode display selection
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    if (p_mode) begin
      state_d = (state_q == RUN) ? ADJ_MIN : RUN;
    end else if (p_sel) begin
      case (state_q)
        RUN:      run_d   = run_q + 2'd1;
        ADJ_MIN:  state_d = ADJ_HOUR;
        ADJ_HOUR: state_d = ADJ_SEC;
        default:  state_d = ADJ_MIN;
      endcase
    end
  end

  assign st_chg = (state_d != state_q);

  // Inc auto-repeat while held in minute/hour adjust
  always_comb begin
    rep_en   = stable_q[2] & armed_q[2] &
               ((state_q == ADJ_MIN) | (state_q == ADJ_HOUR));
    hold_d   = hold_q;
    rep_fire = 1'b0;
    if (!rep_en || st_chg) begin
      hold_d = '0;
    end else if (tick_1ms) begin
      if (hold_q == HW'(REPEAT_DELAY_MS + REPEAT_MS - 1)) begin
        hold_d   = HW'(REPEAT_DELAY_MS);
        rep_fire = 1'b1;
      end else begin
        hold_d   = hold_q + HW'(1);
        rep_fire = (hold_q == HW'(REPEAT_DELAY_MS - 1));
      end
    end
  end

  // Blink phase restarts visible on every state change
  always_comb begin
    blk_d   = blk_q;
    phase_d = phase_q;
    if (st_chg) begin
      blk_d   = '0;
      phase_d = 1'b1;
    end else if (tick_1ms) begin
      if (blk_q == BW'(BLINK_MS - 1)) begin
        blk_d   = '0;
        phase_d = ~phase_q;
      end else begin
        blk_d = blk_q + BW'(1);
      end
    end
  end

  assign inc_ev = p_inc | rep_fire;

  // All state and registered strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= 3'b111;
      sync2_q    <= 3'b111;
      stable_q   <= '0;
      prev_q     <= '0;
      armed_q    <= '0;
      for (int i = 0; i < 3; i++) db_q[i] <= '0;
      state_q    <= RUN;
      run_q      <= 2'd0;
      hold_q     <= '0;
      blk_q      <= '0;
      phase_q    <= 1'b1;
      sec_hold_q <= 1'b0;
      inc_min_q  <= 1'b0;
      inc_hour_q <= 1'b0;
      sec_clr_q  <= 1'b0;
    end else begin
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      stable_q   <= stable_d;
      prev_q     <= stable_q;
      armed_q    <= armed_d;
      for (int i = 0; i < 3; i++) db_q[i] <= db_d[i];
      state_q    <= state_d;
      run_q      <= run_d;
      hold_q     <= hold_d;
      blk_q      <= blk_d;
      phase_q    <= phase_d;
      sec_hold_q <= (state_d == ADJ_SEC);
      inc_min_q  <= inc_ev & (state_q == ADJ_MIN);
      inc_hour_q <= inc_ev & (state_q == ADJ_HOUR);
      sec_clr_q  <= p_inc & (state_q == ADJ_SEC);
    end
  end

  // Display select and blink mask decode
  always_comb begin
    case (state_q)
      RUN: begin
        disp_mode = run_q;
        mask      = 4'b0000;
      end
      ADJ_HOUR: begin
        disp_mode = 2'b01;
        mask      = 4'b1100;
      end
      ADJ_MIN: begin
        disp_mode = 2'b00;
        mask      = 4'b1100;
      end
      default: begin
        disp_mode = 2'b00;
        mask      = 4'b0011;
      end
    endcase
  end

  assign adjust   = (state_q != RUN);
  assign t_blink  = phase_q ? mask : 4'b0000;
  assign sec_hold = sec_hold_q;
  assign inc_min  = inc_min_q;
  assign inc_hour = inc_hour_q;
  assign sec_clr  = sec_clr_q;

endmodule

// File: tb/tb_clock_adjust_ctrl.sv
// Directed bench for clock_adjust_ctrl: vector table plus
// hand sequences for repeat, blink, priority and reset cases.
module tb_clock_adjust_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick_1ms = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_sel = 1'b0;
  logic       btn_inc = 1'b0;
  logic [1:0] disp_mode;
  logic       adjust, sec_hold, sec_clr, inc_min, inc_hour;
  logic [3:0] t_blink;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int tcnt = 0;
  int n_min = 0, n_hour = 0, n_clr = 0;
  int min_cyc [16];
  int min_idx = 0;
  logic pm = 0, ph = 0, pc = 0;

  typedef struct {
    int         btn;
    int         hold;
    logic       adj;
    logic [1:0] disp;
    logic       sh;
    int         dmin;
    int         dhour;
    int         dclr;
  } vec_t;

  vec_t tbl [15];

  clock_adjust_ctrl #(
    .DEBOUNCE_MS(4),
    .REPEAT_DELAY_MS(10),
    .REPEAT_MS(3),
    .BLINK_MS(5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .tick_1ms(tick_1ms),
    .btn_mode(btn_mode),
    .btn_sel(btn_sel),
    .btn_inc(btn_inc),
    .disp_mode(disp_mode),
    .adjust(adjust),
    .sec_hold(sec_hold),
    .sec_clr(sec_clr),
    .inc_min(inc_min),
    .inc_hour(inc_hour),
    .t_blink(t_blink)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    tcnt = (tcnt == 9) ? 0 : tcnt + 1;
    tick_1ms = (tcnt == 9);
  end

  always @(negedge clk) begin
    cyc++;
    if (inc_min) begin
      n_min++;
      if (min_idx < 16) min_cyc[min_idx] = cyc;
      min_idx++;
    end
    if (inc_hour) n_hour++;
    if (sec_clr) n_clr++;
    if (inc_min || inc_hour || sec_clr) begin
      checks++;
      if ((inc_min && pm) || (inc_hour && ph) || (sec_clr && pc)) begin
        errors++;
        $display("FAIL strobe_width: strobe high 2 cycles at cyc %0d", cyc);
      end
    end
    pm = inc_min;
    ph = inc_hour;
    pc = sec_clr;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0:       btn_mode = v;
      1:       btn_sel  = v;
      default: btn_inc  = v;
    endcase
  endtask

  task automatic press(input int b, input int ticks);
    @(negedge clk);
    set_btn(b, 1'b1);
    repeat (ticks * 10) @(negedge clk);
    set_btn(b, 1'b0);
    repeat (65) @(negedge clk);
  endtask

  initial begin
    int bm, bh, bc, base, base2;
    int gaps [4];
    int ok;
    logic [3:0] v, pv;
    int changes, last, bad;

    tbl[0]  = '{0, 3, 1'b0, 2'd0, 1'b0, 0, 0, 0};
    tbl[1]  = '{1, 6, 1'b0, 2'd1, 1'b0, 0, 0, 0};
    tbl[2]  = '{1, 6, 1'b0, 2'd2, 1'b0, 0, 0, 0};
    tbl[3]  = '{1, 6, 1'b0, 2'd3, 1'b0, 0, 0, 0};
    tbl[4]  = '{1, 6, 1'b0, 2'd0, 1'b0, 0, 0, 0};
    tbl[5]  = '{1, 6, 1'b0, 2'd1, 1'b0, 0, 0, 0};
    tbl[6]  = '{2, 6, 1'b0, 2'd1, 1'b0, 0, 0, 0};
    tbl[7]  = '{0, 6, 1'b1, 2'd0, 1'b0, 0, 0, 0};
    tbl[8]  = '{2, 6, 1'b1, 2'd0, 1'b0, 1, 0, 0};
    tbl[9]  = '{1, 6, 1'b1, 2'd1, 1'b0, 0, 0, 0};
    tbl[10] = '{2, 6, 1'b1, 2'd1, 1'b0, 0, 1, 0};
    tbl[11] = '{1, 6, 1'b1, 2'd0, 1'b1, 0, 0, 0};
    tbl[12] = '{2, 6, 1'b1, 2'd0, 1'b1, 0, 0, 1};
    tbl[13] = '{1, 6, 1'b1, 2'd0, 1'b0, 0, 0, 0};
    tbl[14] = '{0, 6, 1'b0, 2'd1, 1'b0, 0, 0, 0};
    gaps = '{10, 3, 3, 3};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_adjust", adjust, 0);
    chk("rst_disp", disp_mode, 0);
    chk("rst_sec_hold", sec_hold, 0);
    chk("rst_blink", t_blink, 0);
    chk("rst_strobes", {inc_min, inc_hour, sec_clr}, 0);
    repeat (5) @(negedge clk);

    for (int i = 0; i < 15; i++) begin
      bm = n_min;
      bh = n_hour;
      bc = n_clr;
      press(tbl[i].btn, tbl[i].hold);
      chk($sformatf("v%0d_adjust", i), adjust, tbl[i].adj);
      chk($sformatf("v%0d_disp", i), disp_mode, tbl[i].disp);
      chk($sformatf("v%0d_sec_hold", i), sec_hold, tbl[i].sh);
      chk($sformatf("v%0d_inc_min", i), n_min - bm, tbl[i].dmin);
      chk($sformatf("v%0d_inc_hour", i), n_hour - bh, tbl[i].dhour);
      chk($sformatf("v%0d_sec_clr", i), n_clr - bc, tbl[i].dclr);
    end

    // entry into ADJ_MIN: blink mask visible on the first cycle
    @(negedge clk);
    btn_mode = 1'b1;
    ok = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (adjust) begin
        ok = 1;
        break;
      end
    end
    chk("entry_seen", ok, 1);
    chk("entry_blink", t_blink, 4'b1100);
    chk("entry_disp", disp_mode, 0);
    btn_mode = 1'b0;
    repeat (65) @(negedge clk);

    // auto-repeat in ADJ_MIN
    base = n_min;
    bh = n_hour;
    bc = n_clr;
    min_idx = 0;
    btn_inc = 1'b1;
    ok = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (n_min > base) begin
        ok = 1;
        break;
      end
    end
    chk("rep_first_seen", ok, 1);
    repeat (168) @(negedge clk);
    btn_inc = 1'b0;
    repeat (80) @(negedge clk);
    chk("rep_count", n_min - base, 5);
    if (min_idx >= 5) begin
      for (int i = 1; i < 5; i++)
        chk($sformatf("rep_gap%0d", i),
            (min_cyc[i] - min_cyc[i-1] + 5) / 10, gaps[i-1]);
    end
    chk("rep_no_hour", n_hour - bh, 0);
    chk("rep_no_clr", n_clr - bc, 0);

    // ADJ_SEC: hold, blink cadence, single clear
    press(1, 6);
    press(1, 6);
    chk("sec_hold", sec_hold, 1);
    chk("sec_disp", disp_mode, 0);
    changes = 0;
    last = -1;
    bad = 0;
    pv = t_blink;
    for (int i = 0; i <= 20; i++) begin
      repeat (10) @(negedge clk);
      v = t_blink;
      if (v != 4'b0011 && v != 4'b0000) bad++;
      if (i > 0 && v != pv) begin
        changes++;
        if (last >= 0) chk("blink_period", i - last, 5);
        last = i;
      end
      pv = v;
    end
    chk("blink_values", bad, 0);
    chk("blink_changes", changes, 4);
    bm = n_min;
    bc = n_clr;
    press(2, 20);
    chk("sec_clr_once", n_clr - bc, 1);
    chk("sec_no_min", n_min - bm, 0);

    // mode wins over sel in ADJ_HOUR
    press(1, 6);
    press(1, 6);
    chk("hour_disp", disp_mode, 1);
    @(negedge clk);
    btn_mode = 1'b1;
    btn_sel = 1'b1;
    repeat (60) @(negedge clk);
    btn_mode = 1'b0;
    btn_sel = 1'b0;
    repeat (65) @(negedge clk);
    chk("msel_adjust", adjust, 0);
    chk("msel_runmode", disp_mode, 1);

    // inc discarded alongside mode
    press(0, 6);
    press(1, 6);
    chk("minc_pre_disp", disp_mode, 1);
    bh = n_hour;
    @(negedge clk);
    btn_mode = 1'b1;
    btn_inc = 1'b1;
    repeat (60) @(negedge clk);
    btn_mode = 1'b0;
    btn_inc = 1'b0;
    repeat (65) @(negedge clk);
    chk("minc_no_hour", n_hour - bh, 0);
    chk("minc_adjust", adjust, 0);

    // reset during auto-repeat with inc held
    press(0, 6);
    chk("rr_adjust", adjust, 1);
    base = n_min;
    btn_inc = 1'b1;
    ok = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (n_min - base >= 2) begin
        ok = 1;
        break;
      end
    end
    chk("rr_repeat_seen", ok, 1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rr_adjust0", adjust, 0);
    chk("rr_disp0", disp_mode, 0);
    chk("rr_blink0", t_blink, 0);
    chk("rr_sec_hold0", sec_hold, 0);
    chk("rr_strobes0", {inc_min, inc_hour, sec_clr}, 0);
    base2 = n_min;
    repeat (150) @(negedge clk);
    press(0, 6);
    chk("rr_readjust", adjust, 1);
    repeat (150) @(negedge clk);
    chk("rr_held_no_strobe", n_min - base2, 0);
    btn_inc = 1'b0;
    repeat (65) @(negedge clk);
    press(2, 6);
    chk("rr_repress", n_min - base2, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_adjust_ctrl.md
Name: clock_adjust_ctrl

Overview:
- Synchronous user-interface controller for the wall-clock datapath (ms/sec/min/hour counters and the 4-digit display mux).
- Debounces the three push buttons and runs the run/adjust state machine.
- Issues single-cycle increment/clear strobes to the time counters, and drives display-mode select, digit blink mask and seconds hold.
- Replaces edge-clocked button logic: everything runs on one clock, gated by the 1 ms tick.

Parameters:
- DEBOUNCE_MS, 20, consecutive 1 ms ticks a raw button must differ from its debounced state before the debounced state flips.
- REPEAT_DELAY_MS, 500, inc hold time before auto-repeat starts.
- REPEAT_MS, 200, auto-repeat period after REPEAT_DELAY_MS.
- BLINK_MS, 250, half-period of the blink phase.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous reset, active-high
- tick_1ms  in  1  one-cycle enable pulse every 1 ms, from the clk_1ms divider
- btn_mode  in  1  raw asynchronous button: toggle run/adjust
- btn_sel  in  1  raw button: next display mode (run) or next field (adjust)
- btn_inc  in  1  raw button: adjust current field
- disp_mode  out  2  display select: 00 mm.ss, 01 hh.mm, 10/11 s.ms
- adjust  out  1  high in any ADJ_* state
- sec_hold  out  1  high in ADJ_SEC; freezes the seconds counter
- sec_clr  out  1  one-cycle strobe: seconds (and ms) set to 0
- inc_min  out  1  one-cycle minute increment strobe
- inc_hour  out  1  one-cycle hour increment strobe
- t_blink  out  4  per-digit blank mask; bit3 is the leftmost digit

Behaviour:
- Reset values: state RUN, disp_mode 00, adjust 0, sec_hold 0, sec_clr/inc_min/inc_hour 0, t_blink 0000. Debounced button states 0, all counters 0, blink phase 1.
- Synchronizer: each raw button passes a 2-flop synchronizer clocked by clk.
- Debounce:
  - Evaluated only on tick_1ms cycles.
  - If synced != stable, the per-button counter increments; when it reaches DEBOUNCE_MS, stable flips and the counter clears.
  - A tick with synced == stable clears the counter.
- Press pulse: one-cycle pulse on a 0->1 transition of a stable state. No pulse on release.
- FSM states: RUN, ADJ_MIN, ADJ_HOUR, ADJ_SEC.
  - mode press: RUN->ADJ_MIN; any ADJ_*->RUN.
  - sel press in RUN: run_mode = run_mode+1, wraps 11->00.
  - sel press in adjust: ADJ_MIN->ADJ_HOUR->ADJ_SEC->ADJ_MIN.
  - inc press: in RUN, ignored. In ADJ_MIN, inc_min. In ADJ_HOUR, inc_hour. In ADJ_SEC, sec_clr.
  - mode and sel press in the same cycle: mode wins, sel is discarded. inc press in the same cycle as mode/sel: inc is discarded.
- Strobe latency: registered, asserted the cycle after the press pulse, high exactly 1 cycle.
- Auto-repeat (ADJ_MIN/ADJ_HOUR only):
  - While inc stays stable-high, a hold counter (on ticks) fires an extra strobe at REPEAT_DELAY_MS, then every REPEAT_MS.
  - Release, or any state change, clears the hold counter.
  - ADJ_SEC never repeats.
- disp_mode:
  - RUN: run_mode.
  - ADJ_MIN and ADJ_SEC: forced 00.
  - ADJ_HOUR: forced 01.
  - run_mode is preserved across adjust and restored on return to RUN.
- Blink:
  - Blink counter counts ticks; phase toggles every BLINK_MS.
  - On every state change, counter clears and phase is set to 1.
  - t_blink = phase ? mask : 0000. Mask is 1100 in ADJ_MIN/ADJ_HOUR, 0011 in ADJ_SEC, and 0000 in RUN regardless of phase.
- sec_hold is a registered decode of ADJ_SEC.
- Reset mid-press or mid-repeat: all counters clear and no strobe is issued. A button still held after reset must first be seen released before it can produce a press.

Test Plan:
- Params DEBOUNCE_MS=4, REPEAT_DELAY_MS=10, REPEAT_MS=3, BLINK_MS=5, tick every 10 clk. Hold btn_mode high for 3 ticks then release -> no state change, adjust stays 0. Hold for 6 ticks -> adjust=1, disp_mode=00, t_blink=1100 in the cycle after entry.
- In RUN, 5 sel presses -> disp_mode steps 01,10,11,00,01. Then mode press -> disp_mode 00. Second mode press -> disp_mode returns to 01.
- ADJ_MIN, hold inc for 20 ticks past debounce -> inc_min pulses at 0, 10, 13, 16, 19 ticks (5 one-cycle strobes). inc_hour and sec_clr stay 0.
- ADJ_MIN, sel twice -> ADJ_SEC: sec_hold=1, t_blink alternates 0011/0000 every 5 ticks. Hold inc 20 ticks -> exactly one sec_clr pulse.
- mode and sel debounced on the same tick in ADJ_HOUR -> state RUN and run_mode unchanged. Same-tick mode+inc -> no inc_hour.
- reset asserted for 1 cycle during auto-repeat with inc held -> all outputs at reset values, no strobes until inc is released and pressed again.
